// File: rtl/vx_result_packet_merger_pkg.sv
// Shared types and widths for the result packet merger: FSM states, latched
// instruction header, and the packet-to-lane offset helper.
package vx_result_packet_merger_pkg;

  localparam int NUM_THREADS   = 4;
  localparam int XLEN          = 32;
  localparam int UUID_WIDTH    = 16;
  localparam int NW_WIDTH      = 2;
  localparam int PC_BITS       = 32;
  localparam int NR_BITS       = 5;
  localparam int PERF_CTR_BITS = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } merge_state_t;

  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [NW_WIDTH-1:0]   wid;
    logic [PC_BITS-1:0]    pc;
    logic                  wb;
    logic [NR_BITS-1:0]    rd;
  } merge_hdr_t;

  // A single-packet configuration still carries a 1-bit (ignored) pid.
  function automatic int pid_width(input int num_packets);
    return (num_packets > 1) ? $clog2(num_packets) : 1;
  endfunction

  function automatic int unsigned pid_to_lane_base(input int unsigned pid,
                                                   input int unsigned num_lanes);
    return pid * num_lanes;
  endfunction

endpackage

// File: rtl/vx_result_packet_merger_if.sv
// Packet-in / commit-out bus of the result packet merger. The merger is the
// slave; the execute-side producer and commit consumer together form the master.
interface vx_result_packet_merger_if
  import vx_result_packet_merger_pkg::*;
#(
  parameter int NUM_LANES = 1
);
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
  localparam int PID_WIDTH   = pid_width(NUM_PACKETS);

  logic                             in_valid;
  logic                             in_ready;
  logic [UUID_WIDTH-1:0]            in_uuid;
  logic [NW_WIDTH-1:0]              in_wid;
  logic [PC_BITS-1:0]               in_pc;
  logic                             in_wb;
  logic [NR_BITS-1:0]               in_rd;
  logic [NUM_LANES-1:0]             in_tmask;
  logic [NUM_LANES-1:0][XLEN-1:0]   in_data;
  logic [PID_WIDTH-1:0]             in_pid;
  logic                             in_sop;
  logic                             in_eop;

  logic                             out_valid;
  logic                             out_ready;
  logic [UUID_WIDTH-1:0]            out_uuid;
  logic [NW_WIDTH-1:0]              out_wid;
  logic [PC_BITS-1:0]               out_pc;
  logic                             out_wb;
  logic [NR_BITS-1:0]               out_rd;
  logic [NUM_THREADS-1:0]           out_tmask;
  logic [NUM_THREADS-1:0][XLEN-1:0] out_data;

  modport master (
    output in_valid, in_uuid, in_wid, in_pc, in_wb, in_rd, in_tmask, in_data,
           in_pid, in_sop, in_eop, out_ready,
    input  in_ready, out_valid, out_uuid, out_wid, out_pc, out_wb, out_rd,
           out_tmask, out_data
  );

  modport slave (
    input  in_valid, in_uuid, in_wid, in_pc, in_wb, in_rd, in_tmask, in_data,
           in_pid, in_sop, in_eop, out_ready,
    output in_ready, out_valid, out_uuid, out_wid, out_pc, out_wb, out_rd,
           out_tmask, out_data
  );

endinterface

// File: rtl/vx_result_packet_merger_lane_buffer.sv
// Per-packet mask/data store. A write replaces one packet's lanes; a sop write
// also zeroes every other packet's mask so no stale lanes survive into a commit.
module vx_merge_lane_buffer
  import vx_result_packet_merger_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int PID_WIDTH = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             wr_en,
  input  logic                             sop_clr,
  input  logic [PID_WIDTH-1:0]             wr_pid,
  input  logic [NUM_LANES-1:0]             wr_mask,
  input  logic [NUM_LANES-1:0][XLEN-1:0]   wr_data,
  output logic [NUM_THREADS-1:0]           tmask,
  output logic [NUM_THREADS-1:0][XLEN-1:0] data
);
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;

  logic [NUM_PACKETS-1:0] pkt_we;

  if (NUM_PACKETS == 1) begin : g_single
    logic unused_pid;
    assign unused_pid = ^wr_pid;
    assign pkt_we     = wr_en;
  end else begin : g_multi
    always_comb begin
      pkt_we         = '0;
      pkt_we[wr_pid] = wr_en;
    end
  end

  for (genvar p = 0; p < NUM_PACKETS; p++) begin : g_pkt
    logic [NUM_LANES-1:0]           mask_q, mask_d;
    logic [NUM_LANES-1:0][XLEN-1:0] data_q, data_d;

    always_comb begin
      mask_d = mask_q;
      data_d = data_q;
      if (pkt_we[p]) begin
        mask_d = wr_mask;
        data_d = wr_data;
      end else if (sop_clr) begin
        mask_d = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) mask_q <= '0;
      else       mask_q <= mask_d;
    end

    // Data lanes are qualified by the mask, so they need no reset.
    always_ff @(posedge clk) data_q <= data_d;

    assign tmask[pid_to_lane_base(p, NUM_LANES) +: NUM_LANES] = mask_q;
    assign data[pid_to_lane_base(p, NUM_LANES) +: NUM_LANES]  = data_q;
  end

endmodule

// File: rtl/vx_result_packet_merger.sv
// Reassembles NUM_LANES-wide result packets into one NUM_THREADS-wide commit.
// Optional perf counters are built when RESULT_MERGE_PERF_EN is defined.
module vx_result_packet_merger
  import vx_result_packet_merger_pkg::*;
#(
  parameter int NUM_LANES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  vx_result_packet_merger_if.slave  bus,
  output logic                      proto_err
`ifdef RESULT_MERGE_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]  perf_stall_cycles,
  output logic [PERF_CTR_BITS-1:0]  perf_merges
`endif
);
  localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES;
  localparam int PID_WIDTH   = pid_width(NUM_PACKETS);

  merge_state_t state_q, state_d;
  merge_hdr_t   hdr_q, hdr_d;
  logic         hdr_valid_q, hdr_valid_d;
  logic         err_q, err_d;
  logic         rdy_en_q, rdy_en_d;
  logic         in_fire, out_fire, hdr_live, pkt_err;

  // in_ready stays low through reset and for the first cycle after it.
  assign bus.in_ready  = rdy_en_q & ((state_q == COLLECT) | bus.out_ready);
  assign bus.out_valid = (state_q == FULL);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign out_fire      = (state_q == FULL) & bus.out_ready;
  assign hdr_live      = hdr_valid_q & (state_q == COLLECT);

  // A header being committed this cycle no longer anchors continuation packets.
  always_comb begin
    pkt_err = 1'b0;
    if (bus.in_sop) pkt_err = hdr_live;
    else            pkt_err = !hdr_live || (bus.in_wid != hdr_q.wid) ||
                              (bus.in_uuid != hdr_q.uuid);
  end

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    hdr_valid_d = hdr_valid_q;
    err_d       = err_q;
    rdy_en_d    = 1'b1;
    if (out_fire) begin
      state_d     = COLLECT;
      hdr_valid_d = 1'b0;
    end
    if (in_fire) begin
      err_d = err_q | pkt_err;
      if (bus.in_sop) begin
        hdr_d       = '{uuid: bus.in_uuid, wid: bus.in_wid, pc: bus.in_pc,
                        wb: bus.in_wb, rd: bus.in_rd};
        hdr_valid_d = 1'b1;
      end
      if (bus.in_eop) state_d = FULL;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= COLLECT;
      hdr_valid_q <= 1'b0;
      err_q       <= 1'b0;
      rdy_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hdr_valid_q <= hdr_valid_d;
      err_q       <= err_d;
      rdy_en_q    <= rdy_en_d;
    end
  end

  always_ff @(posedge clk) hdr_q <= hdr_d;

  assign proto_err    = err_q;
  assign bus.out_uuid = hdr_q.uuid;
  assign bus.out_wid  = hdr_q.wid;
  assign bus.out_pc   = hdr_q.pc;
  assign bus.out_wb   = hdr_q.wb;
  assign bus.out_rd   = hdr_q.rd;

  vx_merge_lane_buffer #(
    .NUM_LANES (NUM_LANES),
    .PID_WIDTH (PID_WIDTH)
  ) lane_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (in_fire),
    .sop_clr (in_fire & bus.in_sop),
    .wr_pid  (bus.in_pid),
    .wr_mask (bus.in_tmask),
    .wr_data (bus.in_data),
    .tmask   (bus.out_tmask),
    .data    (bus.out_data)
  );

`ifdef RESULT_MERGE_PERF_EN
  logic [PERF_CTR_BITS-1:0] stall_q, stall_d, merges_q, merges_d;

  always_comb begin
    stall_d  = stall_q + PERF_CTR_BITS'((state_q == FULL) && !bus.out_ready);
    merges_d = merges_q + PERF_CTR_BITS'(out_fire);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q  <= '0;
      merges_q <= '0;
    end else begin
      stall_q  <= stall_d;
      merges_q <= merges_d;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_merges       = merges_q;
`endif

endmodule
